// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: carries payload, debug PC and valid from one
// stage to the next, honouring stall, flush and bubble insertion, and keeps
// saturating hold/bubble counters for the perf/debug path.
module pipe_stage_reg #(
  parameter int                  DATA_W    = 115,
  parameter int                  STALL_W   = 6,
  parameter int                  STALL_IDX = 4,
  parameter bit                  BUBBLE_EN = 1'b1,
  parameter logic [DATA_W-1:0]   CLR_MASK  = {DATA_W{1'b1}},
  parameter logic [31:0]         PC_INIT   = 32'hbfc00000,
  parameter int                  CNT_W     = 16
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [31:0]        in_pc,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [31:0]        out_pc,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [31:0]       pc_q,    pc_d;
  logic [CNT_W-1:0]  hold_q,  hold_d;
  logic [CNT_W-1:0]  bub_q,   bub_d;

  logic stall_me;
  logic stall_dn;
  logic do_bubble;
  logic unused_stall;

  assign stall_me     = stall[STALL_IDX];
  assign unused_stall = ^stall;

  // The last stage of the stall vector has no downstream neighbour: treat it as running.
  generate
    if (STALL_IDX == STALL_W - 1) begin : g_last
      assign stall_dn = 1'b0;
    end else begin : g_mid
      assign stall_dn = stall[STALL_IDX+1];
    end
  endgenerate

  assign do_bubble = BUBBLE_EN && stall_me && !stall_dn;

  // Next-state selection: flush, then bubble, then advance, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    bub_d   = bub_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = data_q & ~CLR_MASK;
      pc_d    = PC_INIT;
    end else if (do_bubble) begin
      valid_d = 1'b0;
      data_d  = data_q & ~CLR_MASK;
      pc_d    = PC_INIT;
      bub_d   = sat_inc(bub_q);
    end else if (!stall_me) begin
      valid_d = in_valid;
      data_d  = in_data;
      pc_d    = in_pc;
    end else begin
      hold_d  = sat_inc(hold_q);
    end
  end

  // Stage boundary: every output is registered; synchronous reset beats everything.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= PC_INIT;
      hold_q  <= '0;
      bub_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      bub_q   <= bub_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_pc     = pc_q;
  assign hold_cnt   = hold_q;
  assign bubble_cnt = bub_q;

endmodule
